sync_event_receiver: RTL and testbench



---
 rtl/sync_event_pkg.sv | 21 ++
 rtl/sync_event_chan.sv | 121 ++++++++++++
 rtl/sync_event_receiver.sv | 66 ++++++
 tb/tb_sync_event_receiver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sync_event_pkg.sv
`default_nettype none
//==============================================================================
// Module   : sync_event_pkg
// Purpose  : Shared constants and helpers for the sync_event_receiver slice.
//            SYNC_MIN_STAGES is the shortest synchroniser chain the channels
//            accept. cnt_max() gives the saturation value of a pending
//            counter of a given width.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package sync_event_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    // Largest value an unsigned counter of cnt_w bits can hold.
    function automatic int unsigned cnt_max(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage : sync_event_pkg
`default_nettype wire

// File: rtl/sync_event_chan.sv
`default_nettype none
//==============================================================================
// Module   : sync_event_chan
// Purpose  : One event channel of the toggle-protocol receiver. It contains the
//            resynchroniser chain, edge detector, saturating pending counter,
//            return acknowledge toggle and sticky overflow flag.
//            Optional build macro: SYNC_EVENT_AUTOACK_EN. When it is defined,
//            the ack toggle follows every detected edge, including dropped
//            events, and dequeue only decrements the count.
// Ports    : clk_i        - destination clock
//            rst_ni       - asynchronous active-low reset
//            toggle_i     - event toggle from the foreign domain (async)
//            deq_i        - consumer dequeue strobe
//            clr_ovf_i    - synchronous clear of overflow_o
//            pulse_o      - one-cycle pulse per detected toggle edge
//            pending_o    - pending count is non-zero
//            ack_toggle_o - return toggle to the sender
//            overflow_o   - sticky overflow flag
// Revision : 1.0 - initial release
//==============================================================================
module sync_event_chan
    import sync_event_pkg::*;
#(
    parameter int   STAGES = 2,
    parameter int   CNT_W  = 3,
    parameter logic INIT   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic toggle_i,
    input  logic deq_i,
    input  logic clr_ovf_i,
    output logic pulse_o,
    output logic pending_o,
    output logic ack_toggle_o,
    output logic overflow_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(cnt_max(CNT_W));

    generate
        if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
            $error("sync_event_chan: STAGES must be at least SYNC_MIN_STAGES");
        end
    endgenerate

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ack_q;
    logic              ack_d;
    logic              ovf_q;
    logic              ovf_d;

    logic              w_edge;
    logic              w_accept;
    logic              w_ovf_set;
    logic              w_ack_flip;

    // Bit 0 is the metastability-exposed flop; bit STAGES-1 is the settled
    // sample used by the edge detector.
    assign sync_d   = {sync_q[STAGES-2:0], toggle_i};
    assign w_edge   = sync_q[STAGES-1] ^ last_q;
    // A dequeue on an empty channel is ignored entirely (no ack, no wrap).
    assign w_accept = deq_i & (cnt_q != '0);

`ifdef SYNC_EVENT_AUTOACK_EN
    // Acknowledge every detected edge, including events dropped at saturation,
    // so the sender never waits on the consumer.
    assign w_ack_flip = w_edge;
`else
    // Acknowledge only events the consumer has actually taken; a dropped
    // event is never acknowledged.
    assign w_ack_flip = w_accept;
`endif

    // Simultaneous arrival and dequeue cancel out, so a full counter does not
    // overflow in that cycle.
    always_comb begin
        cnt_d     = cnt_q;
        w_ovf_set = 1'b0;
        if (w_edge && !w_accept) begin
            if (cnt_q == c_CNT_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (w_accept && !w_edge) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign ack_d = ack_q ^ w_ack_flip;
    // Set has priority over a clear arriving in the same cycle.
    assign ovf_d = w_ovf_set | (ovf_q & ~clr_ovf_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{INIT}};
            last_q <= INIT;
            cnt_q  <= '0;
            ack_q  <= INIT;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= sync_q[STAGES-1];
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pulse_o      = w_edge;
    assign pending_o    = (cnt_q != '0);
    assign ack_toggle_o = ack_q;
    assign overflow_o   = ovf_q;

endmodule : sync_event_chan
`default_nettype wire

// File: rtl/sync_event_receiver.sv
`default_nettype none
//==============================================================================
// Module   : sync_event_receiver
// Purpose  : Destination-side receiver for WIDTH independent toggle-protocol
//            event crossings. Each channel resynchronises its toggle, detects
//            edges, queues events as a pending count and returns an
//            acknowledge toggle to the sender.
//            Optional build macro: SYNC_EVENT_AUTOACK_EN (see sync_event_chan).
// Ports    : CLK        - destination clock
//            RST        - asynchronous active-low reset
//            sToggle    - per-channel event toggles (asynchronous to CLK)
//            dPulse     - per-channel one-cycle edge pulse
//            dPending   - per-channel pending count non-zero
//            dDeq       - per-channel dequeue strobe
//            dAckToggle - per-channel return toggle
//            dOverflow  - per-channel sticky overflow
//            dClrOvf    - per-channel synchronous overflow clear
// Revision : 1.0 - initial release
//==============================================================================
module sync_event_receiver
    import sync_event_pkg::*;
#(
    parameter int   WIDTH  = 4,
    parameter int   STAGES = 2,
    parameter int   CNT_W  = 3,
    parameter logic init   = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] sToggle,
    output logic [WIDTH-1:0] dPulse,
    output logic [WIDTH-1:0] dPending,
    input  logic [WIDTH-1:0] dDeq,
    output logic [WIDTH-1:0] dAckToggle,
    output logic [WIDTH-1:0] dOverflow,
    input  logic [WIDTH-1:0] dClrOvf
);

    generate
        if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
            $error("sync_event_receiver: STAGES must be at least SYNC_MIN_STAGES");
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            sync_event_chan #(
                .STAGES (STAGES),
                .CNT_W  (CNT_W),
                .INIT   (init)
            ) u_chan (
                .clk_i        (CLK),
                .rst_ni       (RST),
                .toggle_i     (sToggle[gi]),
                .deq_i        (dDeq[gi]),
                .clr_ovf_i    (dClrOvf[gi]),
                .pulse_o      (dPulse[gi]),
                .pending_o    (dPending[gi]),
                .ack_toggle_o (dAckToggle[gi]),
                .overflow_o   (dOverflow[gi])
            );
        end
    endgenerate

endmodule : sync_event_receiver
`default_nettype wire

// File: tb/tb_sync_event_receiver.sv
`default_nettype none
//==============================================================================
// Module   : tb_sync_event_receiver
// Purpose  : Self-checking bench for sync_event_receiver. Random toggles,
//            dequeues and overflow clears are checked every cycle against a
//            history/counter reference model. An asynchronous reset is also
//            applied in the middle of traffic.
// Revision : 1.0 - initial release
//==============================================================================
module tb_sync_event_receiver;

    localparam int   WIDTH  = 4;
    localparam int   STAGES = 2;
    localparam int   CNT_W  = 3;
    localparam logic INIT   = 1'b0;
    localparam int   MAXC   = (1 << CNT_W) - 1;
`ifdef SYNC_EVENT_AUTOACK_EN
    localparam bit   AUTOACK = 1'b1;
`else
    localparam bit   AUTOACK = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] sToggle;
    logic [WIDTH-1:0] dPulse;
    logic [WIDTH-1:0] dPending;
    logic [WIDTH-1:0] dDeq;
    logic [WIDTH-1:0] dAckToggle;
    logic [WIDTH-1:0] dOverflow;
    logic [WIDTH-1:0] dClrOvf;

    sync_event_receiver #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W),
        .init   (INIT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sToggle    (sToggle),
        .dPulse     (dPulse),
        .dPending   (dPending),
        .dDeq       (dDeq),
        .dAckToggle (dAckToggle),
        .dOverflow  (dOverflow),
        .dClrOvf    (dClrOvf)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model. hist[i][k] is the toggle value sampled k+1 edges ago;
    // the receiver sees an event when the sample STAGES edges old differs from
    // the one STAGES+1 edges old.
    logic hist [WIDTH][STAGES+1];
    int   cnt  [WIDTH];
    logic ovf  [WIDTH];
    logic ack  [WIDTH];

    function automatic logic m_pulse(input int i);
        return hist[i][STAGES-1] != hist[i][STAGES];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k <= STAGES; k++) hist[i][k] = INIT;
            cnt[i] = 0;
            ovf[i] = 1'b0;
            ack[i] = INIT;
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input logic [WIDTH-1:0] tog, input logic [WIDTH-1:0] deq,
                              input logic [WIDTH-1:0] clr);
        for (int i = 0; i < WIDTH; i++) begin
            logic p, acc, set;
            p   = m_pulse(i);
            acc = deq[i] && (cnt[i] > 0);
            set = 1'b0;
            if (p && !acc) begin
                if (cnt[i] == MAXC) set = 1'b1;
                else cnt[i] = cnt[i] + 1;
            end else if (acc && !p) begin
                cnt[i] = cnt[i] - 1;
            end
            ovf[i] = set ? 1'b1 : (clr[i] ? 1'b0 : ovf[i]);
            if (AUTOACK ? p : acc) ack[i] = ~ack[i];
            for (int k = STAGES; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = tog[i];
        end
    endtask

    task automatic check_outputs(input string ph);
        logic [WIDTH-1:0] ep, en, ea, eo;
        for (int i = 0; i < WIDTH; i++) begin
            ep[i] = m_pulse(i);
            en[i] = (cnt[i] != 0);
            ea[i] = ack[i];
            eo[i] = ovf[i];
        end
        check_val({ph, "/dPulse"},     32'(dPulse),     32'(ep));
        check_val({ph, "/dPending"},   32'(dPending),   32'(en));
        check_val({ph, "/dAckToggle"}, 32'(dAckToggle), 32'(ea));
        check_val({ph, "/dOverflow"},  32'(dOverflow),  32'(eo));
    endtask

    // Runs n cycles; probabilities are percentages per channel per cycle.
    // Entered and left at a falling clock edge.
    task automatic run_phase(input string ph, input int n, input int p_tog,
                             input int p_deq, input int p_clr);
        for (int c = 0; c < n; c++) begin
            logic [WIDTH-1:0] tog, deq, clr;
            check_outputs(ph);
            for (int i = 0; i < WIDTH; i++) begin
                tog[i] = sToggle[i] ^ ($urandom_range(0, 99) < p_tog);
                deq[i] = ($urandom_range(0, 99) < p_deq);
                clr[i] = ($urandom_range(0, 99) < p_clr);
            end
            sToggle = tog;
            dDeq    = deq;
            dClrOvf = clr;
            model_step(tog, deq, clr);
            @(negedge CLK);
        end
    endtask

    initial begin
        RST     = 1'b0;
        sToggle = {WIDTH{INIT}};
        dDeq    = '0;
        dClrOvf = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_outputs("reset");

        RST = 1'b1;
        run_phase("fill",  60, 50,  5,  5);
        run_phase("mixed", 80, 50, 50, 10);
        run_phase("full",  40, 90, 90, 20);
        run_phase("drain", 40,  0, 80,  5);
        run_phase("refill", 12, 60, 10, 0);

        // Asynchronous reset between clock edges with traffic in flight.
        #2;
        RST     = 1'b0;
        sToggle = {WIDTH{INIT}};
        dDeq    = '0;
        dClrOvf = '0;
        #1;
        check_val("async_rst/dPulse",     32'(dPulse),     32'(0));
        check_val("async_rst/dPending",   32'(dPending),   32'(0));
        check_val("async_rst/dAckToggle", 32'(dAckToggle), 32'({WIDTH{INIT}}));
        check_val("async_rst/dOverflow",  32'(dOverflow),  32'(0));
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        run_phase("post_rst", 10,  0, 0, 0);
        run_phase("rerun",    80, 40, 40, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_event_receiver
`default_nettype wire
